// File: rtl/ita_requant_pipe.sv
// ita_requant_pipe: elastic 3-stage requantizer (multiply, shift, offset + saturate) over N lanes.
// Build option ITA_REQUANT_ROUND_EN: round half toward +inf in the shift stage instead of truncating.
module ita_requant_pipe #(
  parameter int N       = 16,
  parameter int ACC_W   = 26,
  parameter int MULT_W  = 8,
  parameter int SHIFT_W = 8,
  parameter int OUT_W   = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [N*ACC_W-1:0]   data_i,
  input  logic                 last_i,
  input  logic                 requant_mode_i,
  input  logic [MULT_W-1:0]    requant_mult_i,
  input  logic [SHIFT_W-1:0]   requant_shift_i,
  input  logic [OUT_W-1:0]     requant_add_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [N*OUT_W-1:0]   data_o,
  output logic                 last_o,
  output logic                 busy_o
);
  localparam int PW = ACC_W + MULT_W + 1;
  localparam int QW = PW + 1;
  localparam int RW = QW + 1;
  localparam logic signed [RW-1:0] S_MAX = RW'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [RW-1:0] S_MIN = RW'(-(2 ** (OUT_W - 1)));
  localparam logic signed [RW-1:0] U_MAX = RW'((2 ** OUT_W) - 1);

  logic               v1_reg, v2_reg, v3_reg;
  logic               mode1_reg, mode2_reg;
  logic               last1_reg, last2_reg, last3_reg;
  logic [SHIFT_W-1:0] shift1_reg;
  logic [OUT_W-1:0]   add1_reg, add2_reg;
  logic               en1, en2, en3;
  logic               shift_sat;

  // A stage may load when it is empty or its current beat is leaving this cycle.
  assign en3 = !v3_reg || ready_i;
  assign en2 = !v2_reg || en3;
  assign en1 = !v1_reg || en2;

  assign ready_o = en1;
  assign valid_o = v3_reg;
  assign last_o  = last3_reg;
  assign busy_o  = v1_reg || v2_reg || v3_reg;

  assign shift_sat = 32'(shift1_reg) >= 32'(PW);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_reg     <= 1'b0;
      v2_reg     <= 1'b0;
      v3_reg     <= 1'b0;
      mode1_reg  <= 1'b0;
      mode2_reg  <= 1'b0;
      last1_reg  <= 1'b0;
      last2_reg  <= 1'b0;
      last3_reg  <= 1'b0;
      shift1_reg <= '0;
      add1_reg   <= '0;
      add2_reg   <= '0;
    end else begin
      if (en1) begin
        v1_reg <= valid_i;
        if (valid_i) begin
          mode1_reg  <= requant_mode_i;
          last1_reg  <= last_i;
          shift1_reg <= requant_shift_i;
          add1_reg   <= requant_add_i;
        end
      end
      if (en2) begin
        v2_reg <= v1_reg;
        if (v1_reg) begin
          mode2_reg <= mode1_reg;
          last2_reg <= last1_reg;
          add2_reg  <= add1_reg;
        end
      end
      if (en3) begin
        v3_reg <= v2_reg;
        if (v2_reg) last3_reg <= last2_reg;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      logic signed [PW-1:0] x_ext, m_ext, prod, p1_reg;
      logic signed [QW-1:0] p_wide, shifted, q2_reg;
      logic signed [RW-1:0] sum;
      logic [OUT_W-1:0]     sat, d3_reg;

      // Multiplier is unsigned: a zero MSB makes it a non-negative signed operand.
      assign x_ext  = PW'($signed(data_i[gi*ACC_W +: ACC_W]));
      assign m_ext  = PW'($signed({1'b0, requant_mult_i}));
      assign prod   = x_ext * m_ext;
      assign p_wide = QW'(p1_reg);

      always_comb begin
        shifted = '0;
        if (shift_sat) begin
          shifted = {QW{p1_reg[PW-1]}};
`ifdef ITA_REQUANT_ROUND_EN
        end else if (shift1_reg != '0) begin
          shifted = (p_wide + (QW'(1) <<< (shift1_reg - SHIFT_W'(1)))) >>> shift1_reg;
`endif
        end else begin
          shifted = p_wide >>> shift1_reg;
        end
      end

      assign sum = RW'(q2_reg) + RW'($signed(add2_reg));

      always_comb begin
        sat = sum[OUT_W-1:0];
        if (mode2_reg) begin
          if (sum[RW-1])       sat = '0;
          else if (sum > U_MAX) sat = '1;
        end else begin
          if (sum > S_MAX)      sat = S_MAX[OUT_W-1:0];
          else if (sum < S_MIN) sat = S_MIN[OUT_W-1:0];
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          p1_reg <= '0;
          q2_reg <= '0;
          d3_reg <= '0;
        end else begin
          if (en1 && valid_i) p1_reg <= prod;
          if (en2 && v1_reg)  q2_reg <= shifted;
          if (en3 && v2_reg)  d3_reg <= sat;
        end
      end

      assign data_o[gi*OUT_W +: OUT_W] = d3_reg;
    end
  endgenerate

endmodule

// File: tb/tb_ita_requant_pipe.sv
// Self-checking bench for ita_requant_pipe: directed cases plus randomized traffic against
// an arithmetic reference model and an in-order scoreboard.
module tb_ita_requant_pipe;
  localparam int N       = 16;
  localparam int ACC_W   = 26;
  localparam int MULT_W  = 8;
  localparam int SHIFT_W = 8;
  localparam int OUT_W   = 8;
  localparam int PW      = ACC_W + MULT_W + 1;

  logic                 clk_i;
  logic                 rst_i;
  logic                 valid_i;
  logic                 ready_o;
  logic [N*ACC_W-1:0]   data_i;
  logic                 last_i;
  logic                 requant_mode_i;
  logic [MULT_W-1:0]    requant_mult_i;
  logic [SHIFT_W-1:0]   requant_shift_i;
  logic [OUT_W-1:0]     requant_add_i;
  logic                 valid_o;
  logic                 ready_i;
  logic [N*OUT_W-1:0]   data_o;
  logic                 last_o;
  logic                 busy_o;

  ita_requant_pipe #(
    .N(N), .ACC_W(ACC_W), .MULT_W(MULT_W), .SHIFT_W(SHIFT_W), .OUT_W(OUT_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .last_i(last_i), .requant_mode_i(requant_mode_i), .requant_mult_i(requant_mult_i),
    .requant_shift_i(requant_shift_i), .requant_add_i(requant_add_i), .valid_o(valid_o),
    .ready_i(ready_i), .data_o(data_o), .last_o(last_o), .busy_o(busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [N*OUT_W-1:0] data;
    logic               last;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   acc_total = 0;
  int   emit_total = 0;
  int   beat_no = 0;
  bit   last_ready;
  bit   hold_v = 0;
  logic [N*OUT_W-1:0] hold_d;
  logic hold_l;

  function automatic longint floor_div(longint a, longint d);
    longint q;
    q = a / d;
    if ((a % d) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  // Reference: exact integer arithmetic on the mathematical value of each lane.
  function automatic logic [OUT_W-1:0] model_lane(logic [ACC_W-1:0] xr, int mult, int shift,
                                                   int add, bit mode);
    longint x, p, q, r, d;
    x = longint'($signed(xr));
    p = x * longint'(mult);
    if (shift >= PW) begin
      q = (p < 0) ? -1 : 0;
    end else begin
      d = longint'(1) << shift;
`ifdef ITA_REQUANT_ROUND_EN
      if (shift > 0) q = floor_div(p + d / 2, d);
      else           q = p;
`else
      q = floor_div(p, d);
`endif
    end
    r = q + longint'(add);
    if (mode) begin
      if (r < 0) r = 0;
      else if (r > 255) r = 255;
    end else begin
      if (r < -128) r = -128;
      else if (r > 127) r = 127;
    end
    return r[OUT_W-1:0];
  endfunction

  function automatic logic [N*OUT_W-1:0] model_beat();
    logic [N*OUT_W-1:0] v;
    for (int i = 0; i < N; i++)
      v[i*OUT_W +: OUT_W] = model_lane(data_i[i*ACC_W +: ACC_W], int'(requant_mult_i),
                                       int'(requant_shift_i), int'($signed(requant_add_i)),
                                       requant_mode_i);
    return v;
  endfunction

  // Output handshakes are counted at the edge where they complete.
  always @(posedge clk_i) begin
    if (rst_i) hold_v = 0;
    else if (valid_o && ready_i) emit_total++;
  end

  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_i) begin
      if (hold_v) begin
        checks++;
        assert (valid_o === 1'b1 && data_o === hold_d && last_o === hold_l) else begin
          errors++;
          $error("FAIL stall_hold observed valid=%b data=%h last=%b required valid=1 data=%h last=%b",
                 valid_o, data_o, last_o, hold_d, hold_l);
        end
      end
      if (valid_o && ready_i) begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_beat observed data=%h last=%b required no beat", data_o, last_o);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checks++;
          assert (data_o === e.data && last_o === e.last) else begin
            errors++;
            $error("FAIL out_beat observed data=%h last=%b required data=%h last=%b",
                   data_o, last_o, e.data, e.last);
          end
          beat_no++;
          $display("beat %0d out data=%h last=%b", beat_no, data_o, last_o);
        end
      end
      hold_v = valid_o && !ready_i;
      hold_d = data_o;
      hold_l = last_o;
    end
  end

  task automatic step(output bit acc);
    exp_t e;
    @(negedge clk_i);
    if (!rst_i) begin
      checks++;
      assert (ready_o === (((acc_total - emit_total) < 3) || ready_i)) else begin
        errors++;
        $error("FAIL ready_o observed=%b required=%b occupancy=%0d", ready_o,
               (((acc_total - emit_total) < 3) || ready_i), acc_total - emit_total);
      end
    end
    last_ready = ready_o;
    acc = valid_i && ready_o && !rst_i;
    if (acc) begin
      e.data = model_beat();
      e.last = last_i;
      sb.push_back(e);
    end
    @(posedge clk_i);
    if (acc) acc_total++;
    #1;
  endtask

  task automatic set_lanes(int xv);
    for (int i = 0; i < N; i++) data_i[i*ACC_W +: ACC_W] = ACC_W'(xv);
  endtask

  task automatic directed(string tag, int xv, int mult, int shift, int add, bit mode, int expv);
    bit acc;
    int lat;
    logic [OUT_W-1:0] eb;
    logic [N*OUT_W-1:0] ev;
    set_lanes(xv);
    requant_mult_i  = MULT_W'(mult);
    requant_shift_i = SHIFT_W'(shift);
    requant_add_i   = OUT_W'(add);
    requant_mode_i  = mode;
    last_i  = 1'b1;
    ready_i = 1'b1;
    valid_i = 1'b1;
    step(acc);
    valid_i = 1'b0;
    lat = 1;
    while (valid_o !== 1'b1 && lat < 20) begin
      @(posedge clk_i);
      #1;
      lat++;
    end
    eb = expv[OUT_W-1:0];
    ev = {N{eb}};
    checks++;
    assert (lat === 3) else begin
      errors++;
      $error("FAIL %s_latency observed=%0d required=3", tag, lat);
    end
    checks++;
    assert (data_o === ev) else begin
      errors++;
      $error("FAIL %s_data observed=%h required=%h", tag, data_o, ev);
    end
    $display("directed %s lane0=%0d latency=%0d", tag, $signed(data_o[OUT_W-1:0]), lat);
    step(acc);
    step(acc);
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 1) == 1) data_i[i*ACC_W +: ACC_W] = ACC_W'($urandom);
      else data_i[i*ACC_W +: ACC_W] = ACC_W'(int'($urandom_range(0, 4000)) - 2000);
    end
    requant_mult_i  = MULT_W'($urandom_range(0, 255));
    requant_shift_i = ($urandom_range(0, 7) == 0) ? SHIFT_W'($urandom_range(0, 255))
                                                  : SHIFT_W'($urandom_range(0, 12));
    requant_add_i   = OUT_W'($urandom);
    requant_mode_i  = 1'($urandom_range(0, 1));
    last_i          = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    bit saw_block;
    int sent, cyc, base;

    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; data_i = '0; last_i = 1'b0;
    requant_mode_i = 1'b0; requant_mult_i = '0; requant_shift_i = '0; requant_add_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    checks++;
    assert ({valid_o, busy_o, last_o, ready_o} === 4'b0001 && data_o === '0) else begin
      errors++;
      $error("FAIL reset_state observed valid=%b busy=%b last=%b ready=%b data=%h required 0,0,0,1,0",
             valid_o, busy_o, last_o, ready_o, data_o);
    end

    directed("t1_basic", 100, 2, 2, 5, 1'b0, 55);
    directed("t2_sat_neg_s", -1000, 5, 3, 0, 1'b0, -128);
    directed("t2_sat_neg_u", -1000, 5, 3, 0, 1'b1, 0);
    directed("t2_sat_pos_u", 1000, 5, 3, 0, 1'b1, 255);
`ifdef ITA_REQUANT_ROUND_EN
    directed("t3_pos", 7, 1, 1, 0, 1'b0, 4);
    directed("t3_neg", -7, 1, 1, 0, 1'b0, -3);
`else
    directed("t3_pos", 7, 1, 1, 0, 1'b0, 3);
    directed("t3_neg", -7, 1, 1, 0, 1'b0, -4);
`endif
    directed("t4_bigshift_neg", -1, 1, 40, 0, 1'b0, -1);
    directed("t4_bigshift_pos", 1, 1, 40, 0, 1'b0, 0);

    // Five back-to-back beats with the sink stalled in cycles 3..6.
    sent = 0; saw_block = 0; base = emit_total;
    requant_mult_i = 8'd1; requant_shift_i = '0; requant_add_i = '0; requant_mode_i = 1'b0;
    for (int c = 0; c < 30; c++) begin
      ready_i = !(c >= 3 && c <= 6);
      if (sent < 5) begin
        set_lanes((sent + 1) * 10);
        last_i  = (sent == 4);
        valid_i = 1'b1;
      end else begin
        valid_i = 1'b0;
      end
      step(acc);
      if (!last_ready) saw_block = 1;
      if (acc) sent++;
    end
    valid_i = 1'b0;
    checks++;
    assert (saw_block === 1'b1) else begin
      errors++;
      $error("FAIL t5_backpressure observed ready_o_low=%b required=1", saw_block);
    end
    checks++;
    assert (emit_total - base === 5) else begin
      errors++;
      $error("FAIL t5_count observed=%0d required=5", emit_total - base);
    end

    // Reset with beats in flight: everything in the pipe is dropped.
    ready_i = 1'b0;
    set_lanes(77);
    last_i = 1'b1;
    valid_i = 1'b1;
    step(acc);
    step(acc);
    valid_i = 1'b0;
    step(acc);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    checks++;
    assert ({valid_o, busy_o, last_o} === 3'b000 && data_o === '0) else begin
      errors++;
      $error("FAIL t6_reset observed valid=%b busy=%b last=%b data=%h required 0,0,0,0",
             valid_o, busy_o, last_o, data_o);
    end
    rst_i = 1'b0;
    sb.delete();
    acc_total = 0;
    emit_total = 0;
    ready_i = 1'b1;
    repeat (8) step(acc);
    checks++;
    assert (emit_total === 0) else begin
      errors++;
      $error("FAIL t6_no_emit observed=%0d required=0", emit_total);
    end

    // Randomized traffic with random backpressure.
    sent = 0; cyc = 0;
    rand_inputs();
    valid_i = 1'b1;
    while (sent < 150 && cyc < 3000) begin
      ready_i = ($urandom_range(0, 9) < 7);
      step(acc);
      cyc++;
      if (acc) begin
        sent++;
        valid_i = 1'b0;
      end
      if (!valid_i && $urandom_range(0, 4) != 0) begin
        rand_inputs();
        valid_i = 1'b1;
      end
    end
    valid_i = 1'b0;
    checks++;
    assert (sent === 150) else begin
      errors++;
      $error("FAIL rand_sent observed=%0d required=150", sent);
    end
    ready_i = 1'b1;
    cyc = 0;
    while ((sb.size() != 0 || busy_o) && cyc < 50) begin
      step(acc);
      cyc++;
    end
    checks++;
    assert (sb.size() === 0 && busy_o === 1'b0) else begin
      errors++;
      $error("FAIL drain observed pending=%0d busy=%b required pending=0 busy=0", sb.size(), busy_o);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
